// File: rtl/bounce_generator.sv
`default_nettype none
// ============================================================================
// Module      : bounce_generator
// Description : Emulates a mechanical switch. Every change of the clean input
//               level is reproduced on 'out' followed by a burst of glitches
//               (toggle pairs), after which the new level is held for a settle
//               window and a one-cycle 'done' pulse is issued.
//               Glitch spacing comes from a 16-bit Fibonacci LFSR
//               (x^16+x^14+x^13+x^11+1) or, when BOUNCE_GEN_FIXED_EN is
//               defined, from the constant FIXED_INTERVAL.
//
// Parameters  : WIDTH          interval counter width (2..16)
//               BOUNCES        glitches (toggle pairs) per burst, 0 allowed
//               SETTLE_CYCLES  hold time after the last edge (>= 1)
//               LFSR_SEED      LFSR reset value (0 is replaced by 1)
//               FIXED_INTERVAL only with BOUNCE_GEN_FIXED_EN
//
// Ports       : clk    in  system clock
//               rst    in  synchronous active-high reset (wins over en)
//               en     in  clock enable, every register holds when low
//               level  in  clean target level
//               out    out bouncy output
//               busy   out high whenever the FSM is not idle
//               done   out one-cycle pulse at the end of the settle window
//
// Optional    : `define BOUNCE_GEN_FIXED_EN -> fixed interval, no LFSR
//
// Revision    : 1.0 - initial release
// ============================================================================
module bounce_generator #(
    parameter int          WIDTH          = 8,
    parameter int          BOUNCES        = 3,
    parameter int          SETTLE_CYCLES  = 256,
`ifdef BOUNCE_GEN_FIXED_EN
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter int          FIXED_INTERVAL = 4
`else
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic level,
    output logic out,
    output logic busy,
    output logic done
);

    // Counter widths. The toggle counter must hold 2*BOUNCES and be at least
    // one bit wide even when BOUNCES is 0.
    localparam int c_TOG_W    = $clog2(2 * BOUNCES + 2);
    localparam int c_SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [c_TOG_W-1:0]    c_TOG_INIT   = c_TOG_W'(2 * BOUNCES);
    localparam logic [c_TOG_W-1:0]    c_TOG_ONE    = c_TOG_W'(1);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_LD  = c_SETTLE_W'(SETTLE_CYCLES);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_ONE = c_SETTLE_W'(1);
    localparam logic [WIDTH-1:0]      c_INT_ONE    = WIDTH'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BOUNCE = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    logic [1:0]            r_state;
    logic                  r_out;
    logic                  r_done;
    logic                  r_target;
    logic [WIDTH-1:0]      r_int_cnt;
    logic [c_TOG_W-1:0]    r_toggles_left;
    logic [c_SETTLE_W-1:0] r_settle_cnt;
    logic [WIDTH-1:0]      w_interval;

`ifdef BOUNCE_GEN_FIXED_EN
    assign w_interval = WIDTH'(FIXED_INTERVAL);
`else
    // A zero seed would lock the LFSR up, so it is replaced by 1.
    localparam logic [15:0] c_SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    logic [15:0]      r_lfsr;
    logic             w_lfsr_fb;
    logic [WIDTH-1:0] w_lfsr_low;

    // Taps 16,14,13,11 -> bits 15,13,12,10; shift towards the MSB.
    assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_lfsr_low = r_lfsr[WIDTH-1:0];
    // A zero interval would never reach the reload point, so it becomes 1.
    assign w_interval = (w_lfsr_low == '0) ? c_INT_ONE : w_lfsr_low;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= c_SEED;
        end else if (en) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_out          <= 1'b0;
            r_done         <= 1'b0;
            r_target       <= 1'b0;
            r_int_cnt      <= '0;
            r_toggles_left <= '0;
            r_settle_cnt   <= '0;
        end else if (en) begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_out <= r_target;
                    if (level != r_target) begin
                        r_target       <= level;
                        r_out          <= level;
                        r_toggles_left <= c_TOG_INIT;
                        r_int_cnt      <= w_interval;
                        if (BOUNCES == 0) begin
                            r_settle_cnt <= c_SETTLE_LD;
                            r_state      <= S_SETTLE;
                        end else begin
                            r_state <= S_BOUNCE;
                        end
                    end
                end

                S_BOUNCE: begin
                    // Reload happens at 1, so the counter never wraps.
                    if (r_int_cnt == c_INT_ONE) begin
                        r_out          <= ~r_out;
                        r_toggles_left <= r_toggles_left - c_TOG_ONE;
                        r_int_cnt      <= w_interval;
                        // Even toggle count: out is back at target here.
                        if (r_toggles_left == c_TOG_ONE) begin
                            r_settle_cnt <= c_SETTLE_LD;
                            r_state      <= S_SETTLE;
                        end
                    end else begin
                        r_int_cnt <= r_int_cnt - c_INT_ONE;
                    end
                end

                S_SETTLE: begin
                    r_out <= r_target;
                    if (r_settle_cnt == c_SETTLE_ONE) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    r_settle_cnt <= r_settle_cnt - c_SETTLE_ONE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out  = r_out;
    assign done = r_done;
    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bounce_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_bounce_generator
// Description : Self-checking bench for bounce_generator. A deadline-based
//               reference model (absolute enabled-edge times for each toggle
//               and for done) predicts out/busy/done every cycle; burst-level
//               properties (edge count per burst, gap bounds) are also
//               checked from the observed output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bounce_generator;

    localparam int          c_WIDTH   = 8;
    localparam int          c_BOUNCES = 3;
    localparam int          c_SETTLE  = 32;
    localparam int          c_FIXED   = 4;
    localparam logic [15:0] c_SEED    = 16'hACE1;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic en    = 1'b0;
    logic level = 1'b0;
    logic out;
    logic busy;
    logic done;

    bounce_generator #(
        .WIDTH         (c_WIDTH),
        .BOUNCES       (c_BOUNCES),
        .SETTLE_CYCLES (c_SETTLE),
`ifdef BOUNCE_GEN_FIXED_EN
        .LFSR_SEED     (c_SEED),
        .FIXED_INTERVAL(c_FIXED)
`else
        .LFSR_SEED     (c_SEED)
`endif
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .level(level),
        .out  (out),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase: 0 idle, 1 bouncing, 2 settling. Events are scheduled as absolute
    // enabled-edge numbers rather than as counters.
    int          m_phase;
    logic        m_out;
    logic        m_target;
    logic        m_done;
    longint      m_edge;
    longint      m_deadline;
    int          m_toggles_rem;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic int model_interval();
`ifdef BOUNCE_GEN_FIXED_EN
        return c_FIXED;
`else
        int v;
        v = int'(m_lfsr) % (1 << c_WIDTH);
        return (v == 0) ? 1 : v;
`endif
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic l);
        int iv;
        if (r) begin
            m_phase = 0; m_out = 1'b0; m_target = 1'b0; m_done = 1'b0;
            m_lfsr = (c_SEED == 16'h0) ? 16'h1 : c_SEED;
        end else if (e) begin
            m_edge++;
            iv = model_interval();
            m_done = 1'b0;
            case (m_phase)
                0: if (l != m_target) begin
                    m_target = l;
                    m_out = l;
                    if (c_BOUNCES == 0) begin
                        m_phase = 2; m_deadline = m_edge + c_SETTLE;
                    end else begin
                        m_phase = 1; m_deadline = m_edge + iv;
                        m_toggles_rem = 2 * c_BOUNCES;
                    end
                end
                1: if (m_edge == m_deadline) begin
                    m_out = ~m_out;
                    m_toggles_rem--;
                    if (m_toggles_rem == 0) begin
                        m_phase = 2; m_deadline = m_edge + c_SETTLE;
                    end else begin
                        m_deadline = m_edge + iv;
                    end
                end
                default: if (m_edge == m_deadline) begin
                    m_done = 1'b1; m_phase = 0;
                end
            endcase
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    // ---------------- observed burst statistics ----------------
    logic   prev_out  = 1'b0;
    logic   prev_done = 1'b0;
    int     trans_cnt = 0;
    longint last_trans_edge = 0;

    task automatic step(input logic r, input logic e, input logic l);
        longint gap;
        rst = r; en = e; level = l;
        @(posedge clk);
        model_edge(r, e, l);
        #1;
        check("out",  out,  m_out);
        check("busy", busy, (m_phase != 0));
        check("done", done, m_done);
        if (r) begin
            trans_cnt = 0;
        end else begin
            if (out !== prev_out) begin
                if (trans_cnt > 0) begin
                    gap = m_edge - last_trans_edge;
                    check("gap_in_range", (gap >= 1 && gap <= (1 << c_WIDTH) - 1), 1);
                end
                trans_cnt++;
                last_trans_edge = m_edge;
            end
            if (done === 1'b1 && prev_done !== 1'b1) begin
                check("burst_edges", trans_cnt, 2 * c_BOUNCES + 1);
                check("done_level", out, m_target);
                trans_cnt = 0;
            end
        end
        prev_out  = out;
        prev_done = done;
    endtask

    task automatic run(input int n, input logic l);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, l);
    endtask

    initial begin
        logic lv;
        int   guard;
        m_edge = 0; m_deadline = 0; m_toggles_rem = 0;
        model_edge(1'b1, 1'b1, 1'b0);

        // Reset held with level=1, burst starts right after release.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        run(60, 1'b1);

        // Falling burst with a 10-cycle enable stall after the 6th edge.
        run(7, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        run(60, 1'b0);

        // Level returns mid-burst; a new burst follows the done edge.
        run(5, 1'b1);
        run(100, 1'b0);

        // Reset in the middle of a burst, then a fresh rising burst.
        run(6, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        run(60, 1'b1);

        // Randomized level changes with random enable gaps and level noise.
        lv = level;
        for (int b = 0; b < 20; b++) begin
            guard = 0;
            while ((m_phase != 0 || m_done) && guard < 20000) begin
                step(1'b0, ($urandom_range(0, 7) != 0), lv);
                guard++;
            end
            check("idle_timeout", (guard < 20000), 1);
            lv = ~lv;
            guard = 0;
            step(1'b0, 1'b1, lv);
            while ((m_phase != 0 || m_done) && guard < 20000) begin
                if ($urandom_range(0, 49) == 0) lv = ~lv;
                step(1'b0, ($urandom_range(0, 7) != 0), lv);
                guard++;
            end
            check("burst_timeout", (guard < 20000), 1);
        end
        run(5, lv);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
